// File: rtl/clock_meter.sv
// Measures the period and high time of a slow asynchronous square wave in clk_in cycles.
// Raises a sticky stall flag when no rising edge arrives within TIMEOUT cycles.
module clock_meter #(
  parameter int unsigned      WIDTH   = 28,
  parameter logic [WIDTH-1:0] TIMEOUT = 28'd100_000_000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             stalled
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_HIGH,
    S_LOW
  } state_e;

  state_e           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_shadow_q, hi_shadow_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             stalled_q, stalled_d;

  logic             rise;
  logic             fall;
  logic             timeout;
  logic [WIDTH-1:0] cnt_inc;

  // s1/s2 resolve metastability; s3 only remembers the previous synchronized level.
  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  assign timeout = (cnt_q == TIMEOUT);
  assign cnt_inc = cnt_q + WIDTH'(1);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can infer a latch.
    state_d     = state_q;
    s1_d        = sig_in;
    s2_d        = s1_q;
    s3_d        = s2_q;
    cnt_d       = cnt_q;
    hi_shadow_d = hi_shadow_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    stalled_d   = stalled_q;

    if (!enable) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      stalled_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ARM;
          cnt_d   = '0;
        end

        S_ARM: begin
          if (rise) begin
            state_d = S_HIGH;
            cnt_d   = WIDTH'(1);
          end else if (timeout) begin
            stalled_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        // A rise cannot follow a rise without a fall in between, so HIGH ignores it.
        // Timeout beats fall here, which keeps cnt from ever passing TIMEOUT.
        S_HIGH: begin
          if (timeout) begin
            state_d   = S_ARM;
            stalled_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
            if (fall) begin
              hi_shadow_d = cnt_q;
              state_d     = S_LOW;
            end
          end
        end

        S_LOW: begin
          if (rise) begin
            period_d    = cnt_q;
            high_time_d = hi_shadow_q;
            valid_d     = 1'b1;
            stalled_d   = 1'b0;
            cnt_d       = WIDTH'(1);
            state_d     = S_HIGH;
          end else if (timeout) begin
            state_d   = S_ARM;
            stalled_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      cnt_q       <= '0;
      hi_shadow_q <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      stalled_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      cnt_q       <= cnt_d;
      hi_shadow_q <= hi_shadow_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      stalled_q   <= stalled_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign stalled   = stalled_q;

endmodule

// File: tb/tb_clock_meter.sv
// Self-checking bench for clock_meter: directed scenarios plus random waves,
// compared every cycle against a timestamp-based reference model.
module tb_clock_meter;

  localparam int unsigned WIDTH = 28;
  localparam int          TMO   = 100;
  localparam int          MAXN  = 65536;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             sig_in;
  logic             enable;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             stalled;

  int n_checks = 0;
  int n_fail   = 0;

  clock_meter #(
    .WIDTH  (WIDTH),
    .TIMEOUT(WIDTH'(TMO))
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .enable   (enable),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .stalled  (stalled)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: edge n is the n-th clk_in rising edge out of reset.
  // A sig_in level sampled at edge k is acted on two edges later.
  int  n        = 0;
  int  first_ok = 0;
  bit  samp [0:MAXN-1];
  bit  m_active    = 1'b0;
  bit  m_have_rise = 1'b0;
  bit  m_fall_seen = 1'b0;
  int  m_t0   = 0;
  int  m_tf   = 0;
  int  m_zref = 0;   // counter value just before edge n is n - m_zref
  logic [WIDTH-1:0] e_period  = '0;
  logic [WIDTH-1:0] e_high    = '0;
  bit               e_valid   = 1'b0;
  bit               e_stalled = 1'b0;

  function automatic bit smp(input int k);
    if (k < first_ok || k < 0 || k >= MAXN) return 1'b0;
    return samp[k];
  endfunction

  task automatic model_reset();
    first_ok    = n + 1;
    m_active    = 1'b0;
    m_have_rise = 1'b0;
    m_fall_seen = 1'b0;
    e_period    = '0;
    e_high      = '0;
    e_valid     = 1'b0;
    e_stalled   = 1'b0;
  endtask

  task automatic model_step();
    bit r, f;
    n = n + 1;
    if (n < MAXN) samp[n] = sig_in;
    r = smp(n - 2) & ~smp(n - 3);
    f = ~smp(n - 2) & smp(n - 3);
    e_valid = 1'b0;
    if (!enable) begin
      m_active  = 1'b0;
      e_stalled = 1'b0;
    end else if (!m_active) begin
      m_active    = 1'b1;
      m_have_rise = 1'b0;
      m_zref      = n + 1;
    end else if (r && (!m_have_rise || m_fall_seen)) begin
      if (m_have_rise) begin
        e_period  = WIDTH'(n - m_t0);
        e_high    = WIDTH'(m_tf - m_t0);
        e_valid   = 1'b1;
        e_stalled = 1'b0;
      end
      m_have_rise = 1'b1;
      m_fall_seen = 1'b0;
      m_t0        = n;
      m_zref      = n;
    end else if (n - m_zref == TMO) begin
      e_stalled   = 1'b1;
      m_have_rise = 1'b0;
      m_zref      = n + 1;
    end else if (f && m_have_rise && !m_fall_seen) begin
      m_fall_seen = 1'b1;
      m_tf        = n;
    end
  endtask

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk_in) begin
    check("period",    32'(period),    32'(e_period));
    check("high_time", 32'(high_time), 32'(e_high));
    check("valid",     32'(valid),     32'(e_valid));
    check("stalled",   32'(stalled),   32'(e_stalled));
  end

  task automatic wave(input int hi, input int lo, input int reps);
    for (int i = 0; i < reps; i++) begin
      sig_in = 1'b1;
      repeat (hi) @(negedge clk_in);
      sig_in = 1'b0;
      repeat (lo) @(negedge clk_in);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_period",  32'(period),    32'd0);
    check("rst_high",    32'(high_time), 32'd0);
    check("rst_valid",   32'(valid),     32'd0);
    check("rst_stalled", 32'(stalled),   32'd0);
    rst_n = 1'b1;
    @(negedge clk_in);
    enable = 1'b1;

    // period 7, high 4
    wave(4, 3, 6);
    check("d7_period", 32'(period),    32'd7);
    check("d7_high",   32'(high_time), 32'd4);

    // asynchronous reset mid-measurement, checked between edges
    sig_in = 1'b1;
    repeat (3) @(negedge clk_in);
    @(posedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    check("arst_period",  32'(period),    32'd0);
    check("arst_high",    32'(high_time), 32'd0);
    check("arst_valid",   32'(valid),     32'd0);
    check("arst_stalled", 32'(stalled),   32'd0);
    @(negedge clk_in);
    rst_n  = 1'b1;
    sig_in = 1'b0;
    repeat (2) @(negedge clk_in);
    wave(4, 3, 4);

    // period 10, high 5
    wave(5, 5, 6);
    check("d10_period", 32'(period),    32'd10);
    check("d10_high",   32'(high_time), 32'd5);

    // stall: one rise then a long low
    sig_in = 1'b1;
    repeat (4) @(negedge clk_in);
    sig_in = 1'b0;
    repeat (300) @(negedge clk_in);
    check("stall_flag",   32'(stalled), 32'd1);
    check("stall_period", 32'(period),  32'd10);
    wave(4, 4, 5);
    check("resume_stalled", 32'(stalled),   32'd0);
    check("resume_period",  32'(period),    32'd8);
    check("resume_high",    32'(high_time), 32'd4);

    // enable drop while high
    sig_in = 1'b1;
    repeat (2) @(negedge clk_in);
    enable = 1'b0;
    repeat (5) @(negedge clk_in);
    check("endrop_valid",   32'(valid),     32'd0);
    check("endrop_stalled", 32'(stalled),   32'd0);
    check("endrop_period",  32'(period),    32'd8);
    check("endrop_high",    32'(high_time), 32'd4);
    enable = 1'b1;
    repeat (2) @(negedge clk_in);
    sig_in = 1'b0;
    repeat (4) @(negedge clk_in);
    wave(3, 6, 4);
    check("reen_period", 32'(period),    32'd9);
    check("reen_high",   32'(high_time), 32'd3);

    // rise coincides with cnt == TIMEOUT: rise wins
    wave(50, 50, 4);
    check("tmo_eq_period",  32'(period),    32'd100);
    check("tmo_eq_high",    32'(high_time), 32'd50);
    check("tmo_eq_stalled", 32'(stalled),   32'd0);

    // one cycle longer than TIMEOUT: always times out, period holds
    wave(50, 51, 3);
    check("tmo_gt_stalled", 32'(stalled), 32'd1);
    check("tmo_gt_period",  32'(period),  32'd100);

    // random duty cycles with occasional stalls and enable drops
    for (int it = 0; it < 150; it++) begin
      int hi;
      int lo;
      hi = int'($urandom_range(30, 2));
      lo = int'($urandom_range(30, 2));
      wave(hi, lo, 1);
      if ($urandom_range(19, 0) == 0) begin
        sig_in = 1'b0;
        repeat ($urandom_range(250, 120)) @(negedge clk_in);
      end
      if ($urandom_range(24, 0) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(8, 1)) @(negedge clk_in);
        enable = 1'b1;
      end
    end
    wave(6, 2, 4);
    check("final_period", 32'(period),    32'd8);
    check("final_high",   32'(high_time), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_meter.md
# clock_meter

Measures the frequency and duty cycle of a slow, asynchronous square-wave input in the fast board-clock domain. It is the inverse of the clock divider: the divider turns a divisor into a frequency, and this block turns a frequency back into a cycle count. It sits beside the divided CPU clock and feeds a debug/seven-segment readout, confirming the 6502 clock rate and duty cycle on hardware.

## Interface

Parameters:
- WIDTH, 28, width of all counters and measured outputs.
- TIMEOUT, 28'd100_000_000, number of clk_in cycles without a sig_in rising edge before `stalled` asserts. Must satisfy 2 ≤ TIMEOUT ≤ 2^WIDTH−1.

Ports:
- clk_in  input  1  board clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- sig_in  input  1  signal under measurement, asynchronous to clk_in.
- enable  input  1  measurement enable, synchronous.
- period  output  WIDTH  clk_in cycles between the last two sig_in rising edges.
- high_time  output  WIDTH  clk_in cycles sig_in was high within that period.
- valid  output  1  one-cycle pulse when period/high_time update.
- stalled  output  1  level; no rising edge seen within TIMEOUT cycles.

## Operation

- **Synchronizer:** two flops s1→s2, then a history flop s3. `rise = s2 & ~s3`, `fall = ~s2 & s3`. All three reset to 0.
- **States:**
  - IDLE: enable=1 → ARM with cnt=0.
  - ARM: waiting for the first rise. On rise → HIGH with cnt=1. No publish.
  - HIGH: on fall, hi_shadow<=cnt, → LOW.
  - LOW: on rise, period<=cnt, high_time<=hi_shadow, valid<=1, stalled<=0, cnt<=1, → HIGH.
- **Counting:** in ARM/HIGH/LOW, cnt increments by 1 every cycle unless reloaded. If sig_in rises at cycles t0 and t1, period = t1−t0. If it falls at tf, high_time = tf−t0.
- **Timeout:** in ARM/HIGH/LOW, if cnt == TIMEOUT and no rise occurs this cycle:
  - stalled<=1, → ARM, cnt<=0.
  - period and high_time hold their last values.
  - stalled stays set through further timeouts and clears only on the next valid.
- **Width rule:** cnt never exceeds TIMEOUT, so it never wraps.
- **enable=0 (any state):** → IDLE, cnt<=0, valid<=0, stalled<=0. period and high_time hold. The synchronizer keeps running.
- **Simultaneous events:** rise and timeout in the same cycle → the rise wins (publish, stalled cleared). rise in HIGH cannot occur after synchronization; if seen, it is ignored.
- **Reset (any time, including mid-measurement):** state=IDLE, cnt=0, hi_shadow=0, period=0, high_time=0, valid=0, stalled=0, s1/s2/s3=0.

## Timing

- All outputs are registered. valid is high for exactly one clk_in cycle.
- **Latency:** if clk_in edge k is the first to sample sig_in high, valid is high after edge k+2 (three edges: k, k+1, k+2). The new period/high_time are visible in that same cycle.
- Synchronizer delay is identical for both edges, so it does not bias the measured values.
- **Minimum measurable signal:** high ≥ 2 and low ≥ 2 clk_in cycles. Narrower pulses may be missed by the synchronizer.
- **First valid:** no valid before the second rising edge after ARM is entered.
- **Updates:** valid recurs once per sig_in period while enabled. Between pulses, outputs are stable.

## Test plan

- **Reset values:** assert rst_n=0 mid-count, async, between clk_in edges → all outputs read 0 immediately. Release rst_n, set enable=1, drive a period-7 wave → first valid only after the second rise.
- **Duty cycle:** drive sig_in from the clock divider with DIVISOR=7 (high 4, low 3) → every valid shows period=7, high_time=4. Repeat with DIVISOR=10 → period=10, high_time=5.
- **Stall:** TIMEOUT=100, hold sig_in low after one rise → stalled=1 exactly 100 cycles after ARM/last reload; period unchanged. Then resume a period-8 wave → stalled stays 1 until the first valid, which clears it and reports period=8.
- **Latency:** force sig_in high just before edge k during LOW → valid is seen after edge k+2 and lasts exactly 1 cycle.
- **Enable drop:** drop enable for 5 cycles mid-HIGH → valid=0, stalled=0, period/high_time hold. Re-enable → next valid only after two new rises, with correct values.
- **Rise vs timeout:** with TIMEOUT=12 and a period-12 wave → the rise coincides with cnt==TIMEOUT; stalled stays 0 and period=12.
